// File: rtl/prog_mem_pkg.sv
// Shared widths, NOP encoding and load FSM state type for the loadable program memory.
package prog_mem_pkg;

  localparam int unsigned DEF_OPC_W   = 5;
  localparam int unsigned DEF_FIELD_W = 8;
  localparam int unsigned DEF_INSTR_W = DEF_OPC_W + 3 * DEF_FIELD_W;

  localparam logic [DEF_INSTR_W-1:0] NOP = '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } load_state_e;

endpackage

// File: rtl/prog_mem_array.sv
// Instruction storage: one synchronous write port, one registered read port with enable.
module prog_mem_array
  import prog_mem_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_INSTR_W,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is deliberately not reset; callers keep both addresses below DEPTH.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/prog_mem_loadable.sv
// Writable instruction memory with registered fetch, stall hold and a streaming load FSM.
module prog_mem_loadable
  import prog_mem_pkg::*;
#(
  parameter int unsigned OPC_W   = DEF_OPC_W,
  parameter int unsigned FIELD_W = DEF_FIELD_W,
  parameter int unsigned INSTR_W = OPC_W + 3 * FIELD_W,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DEPTH   = 256
) (
  input  logic               in_clk,
  input  logic               in_rst,
  input  logic               in_fetch_req,
  input  logic [ADDR_W-1:0]  in_fetch_add,
  input  logic               in_stall,
  output logic [INSTR_W-1:0] out_instruction,
  output logic               out_valid,
  output logic               out_addr_err,
  input  logic               in_load_start,
  input  logic [ADDR_W-1:0]  in_load_base,
  input  logic [ADDR_W:0]    in_load_count,
  input  logic               in_load_valid,
  input  logic [INSTR_W-1:0] in_load_data,
  output logic               out_load_ready,
  output logic               out_load_busy,
  output logic               out_load_done
);

  localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

  load_state_e        state_q;
  logic [ADDR_W-1:0]  wr_ptr_q;
  logic [ADDR_W:0]    remaining_q;
  logic               inst_sel_q;
  logic               hold;
  logic               fetch_in_range;
  logic               serve;
  logic               rd_en;
  logic               load_we;
  logic               mem_we;
  logic [INSTR_W-1:0] rd_data;

  assign hold           = out_valid & in_stall;
  assign fetch_in_range = {1'b0, in_fetch_add} < DEPTH_LIM;
  // A load start in the same cycle wins over the fetch.
  assign serve          = (state_q == S_IDLE) & ~in_load_start & in_fetch_req & ~hold;
  assign rd_en          = serve & fetch_in_range;
  assign load_we        = out_load_ready & in_load_valid;
  assign mem_we         = load_we & ({1'b0, wr_ptr_q} < DEPTH_LIM);

  prog_mem_array #(
    .WIDTH (INSTR_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_array (
    .clk  (in_clk),
    .we   (mem_we),
    .waddr(wr_ptr_q),
    .wdata(in_load_data),
    .re   (rd_en),
    .raddr(in_fetch_add),
    .rdata(rd_data)
  );

  // The array has no reset, so a reset or out-of-range fetch selects NOP instead of rd_data.
  assign out_instruction = inst_sel_q ? rd_data : INSTR_W'(NOP);

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      out_valid    <= 1'b0;
      out_addr_err <= 1'b0;
      inst_sel_q   <= 1'b0;
    end else if (!hold) begin
      out_valid <= serve;
      if (serve) begin
        out_addr_err <= ~fetch_in_range;
        inst_sel_q   <= fetch_in_range;
      end
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q        <= S_IDLE;
      wr_ptr_q       <= '0;
      remaining_q    <= '0;
      out_load_ready <= 1'b0;
      out_load_busy  <= 1'b0;
      out_load_done  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_load_start) begin
            wr_ptr_q      <= in_load_base;
            remaining_q   <= in_load_count;
            out_load_busy <= 1'b1;
            if (in_load_count == '0) begin
              state_q       <= S_DONE;
              out_load_done <= 1'b1;
            end else begin
              state_q        <= S_LOAD;
              out_load_ready <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (load_we) begin
            wr_ptr_q    <= (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + PTR_ONE;
            remaining_q <= remaining_q - CNT_ONE;
            if (remaining_q == CNT_ONE) begin
              state_q        <= S_DONE;
              out_load_ready <= 1'b0;
              out_load_done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q       <= S_IDLE;
          out_load_busy <= 1'b0;
          out_load_done <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
